// File: rtl/tag_pool_manager_pkg.sv
// Shared types for the tag pool manager: per-slot state encoding and width helpers.
package tag_pool_manager_pkg;

  localparam int TAG_STATE_W = 3;

  typedef enum logic [TAG_STATE_W-1:0] {
    TAG_FREE          = 3'd0,
    TAG_LDMEM         = 3'd1,
    TAG_COMPUTE       = 3'd2,
    TAG_COMPUTE_CHECK = 3'd3,
    TAG_STMEM         = 3'd4
  } tag_state_e;

  // Tag ID width, never narrower than one bit.
  function automatic int tag_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tag_pool_manager_if.sv
// Controller/engine-facing signals of the tag pool manager.
interface tag_pool_manager_if #(
  parameter int TAG_W = 1
);
  // Each *_ready/*_done pair is a valid/ready handshake: the manager holds ready with
  // a stable ID; a done is accepted only in a cycle where the matching ready is high,
  // and a done seen while ready is low has no effect.
  logic             tag_req;
  logic             tag_reuse;
  logic             tag_flush;
  logic             tag_bias_prev_sw;
  logic             tag_ddr_pe_sw;
  logic             tag_ready;
  logic [TAG_W-1:0] tag_id;
  logic             ldmem_tag_ready;
  logic [TAG_W-1:0] ldmem_tag_id;
  logic             ldmem_tag_done;
  logic             compute_tag_ready;
  logic [TAG_W-1:0] compute_tag_id;
  logic             compute_bias_prev_sw;
  logic             compute_tag_done;
  logic             next_compute_tag;
  logic             stmem_tag_ready;
  logic [TAG_W-1:0] stmem_tag_id;
  logic             stmem_ddr_pe_sw;
  logic             stmem_tag_done;
  logic             reuse_overflow;

  modport master (
    output tag_req, tag_reuse, tag_flush, tag_bias_prev_sw, tag_ddr_pe_sw,
    output ldmem_tag_done, compute_tag_done, stmem_tag_done,
    input  tag_ready, tag_id, ldmem_tag_ready, ldmem_tag_id,
    input  compute_tag_ready, compute_tag_id, compute_bias_prev_sw, next_compute_tag,
    input  stmem_tag_ready, stmem_tag_id, stmem_ddr_pe_sw, reuse_overflow
  );

  modport slave (
    input  tag_req, tag_reuse, tag_flush, tag_bias_prev_sw, tag_ddr_pe_sw,
    input  ldmem_tag_done, compute_tag_done, stmem_tag_done,
    output tag_ready, tag_id, ldmem_tag_ready, ldmem_tag_id,
    output compute_tag_ready, compute_tag_id, compute_bias_prev_sw, next_compute_tag,
    output stmem_tag_ready, stmem_tag_id, stmem_ddr_pe_sw, reuse_overflow
  );
endinterface

// File: rtl/tag_pool_manager_slot.sv
// One buffer slot: lifecycle FSM, pending compute-pass count, flush mark and sidebands.
module tag_pool_manager_slot
  import tag_pool_manager_pkg::*;
#(
  parameter int REUSE_CNT_W   = 3,
  parameter int STORE_ENABLED = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic       reuse_i,
  input  logic       flush_i,
  input  logic       ld_done_i,
  input  logic       cmp_done_i,
  input  logic       st_done_i,
  input  logic       bias_sw_i,
  input  logic       ddr_sw_i,
  output tag_state_e state_o,
  output logic       bias_o,
  output logic       ddr_o,
  output logic       retire_o,
  output logic       sat_o
);

  localparam logic [REUSE_CNT_W-1:0] CNT_MAX = '1;

  tag_state_e             state_q, state_d;
  logic [REUSE_CNT_W-1:0] cnt_q, cnt_d;
  logic                   flush_q, flush_d;
  logic                   bias_q, bias_d;
  logic                   rbias_q, rbias_d;
  logic                   ddr_q, ddr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TAG_FREE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      bias_q  <= 1'b0;
      rbias_q <= 1'b0;
      ddr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      bias_q  <= bias_d;
      rbias_q <= rbias_d;
      ddr_q   <= ddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    bias_d   = bias_q;
    rbias_d  = rbias_q;
    ddr_d    = ddr_q;
    retire_o = 1'b0;
    sat_o    = 1'b0;

    // A reuse landing on the pass that just finished cancels that pass's decrement.
    if (reuse_i) begin
      ddr_d   = ddr_sw_i;
      rbias_d = bias_sw_i;
      if (!(state_q == TAG_COMPUTE && cmp_done_i)) begin
        if (cnt_q == CNT_MAX) sat_o = 1'b1;
        else                  cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      TAG_FREE: if (req_i) begin
        state_d = TAG_LDMEM;
        cnt_d   = REUSE_CNT_W'(1);
        flush_d = 1'b0;
        bias_d  = bias_sw_i;
        ddr_d   = ddr_sw_i;
      end
      TAG_LDMEM: if (ld_done_i) state_d = TAG_COMPUTE;
      TAG_COMPUTE: if (cmp_done_i) begin
        state_d = TAG_COMPUTE_CHECK;
        bias_d  = rbias_q;
        if (!reuse_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      TAG_COMPUTE_CHECK: begin
        if (cnt_q != '0) begin
          state_d = TAG_COMPUTE;
        end else if (flush_q) begin
          retire_o = 1'b1;
          flush_d  = 1'b0;
          state_d  = (STORE_ENABLED != 0) ? TAG_STMEM : TAG_FREE;
        end
      end
      TAG_STMEM: if (st_done_i) state_d = TAG_FREE;
      default: state_d = TAG_FREE;
    endcase

    if (flush_i) flush_d = 1'b1;
  end

  assign state_o = state_q;
  assign bias_o  = bias_q;
  assign ddr_o   = ddr_q;

endmodule

// File: rtl/tag_pool_manager.sv
// N-way buffer-slot tag manager: issues slot IDs to load/compute/store engines in allocation order.
module tag_pool_manager
  import tag_pool_manager_pkg::*;
#(
  parameter int NUM_TAGS      = 2,
  parameter int TAG_W         = tag_w_f(NUM_TAGS),
  parameter int REUSE_CNT_W   = 3,
  parameter int STORE_ENABLED = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  tag_pool_manager_if.slave               bus,
  output logic [NUM_TAGS*TAG_STATE_W-1:0] dbg_slot_state_o
);

  logic [TAG_W-1:0] alloc_q, alloc_d, ld_q, ld_d, cmp_q, cmp_d, st_q, st_d;
  logic [TAG_W-1:0] last_ptr, flush_tgt;
  logic             ovf_q, ovf_d;

  tag_state_e          slot_state [NUM_TAGS];
  logic [NUM_TAGS-1:0] req_sel, reuse_sel, flush_sel, ld_sel, cmp_sel, st_sel;
  logic [NUM_TAGS-1:0] slot_bias, slot_ddr, slot_retire, slot_sat;
  logic                tag_ready, ld_ready, cmp_ready, st_ready;
  logic                req_acc, ld_acc, cmp_acc, st_acc, retire;

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tag_ready = (slot_state[alloc_q] == TAG_FREE);
  assign ld_ready  = (slot_state[ld_q] == TAG_LDMEM);
  assign cmp_ready = (slot_state[cmp_q] == TAG_COMPUTE);
  assign st_ready  = (STORE_ENABLED != 0) && (slot_state[st_q] == TAG_STMEM);
  assign retire    = slot_retire[cmp_q];

  assign req_acc = bus.tag_req && tag_ready;
  assign ld_acc  = bus.ldmem_tag_done && ld_ready;
  assign cmp_acc = bus.compute_tag_done && cmp_ready;
  assign st_acc  = bus.stmem_tag_done && st_ready;

  // A flush in the same cycle as an accepted req belongs to the slot being allocated.
  assign last_ptr  = (alloc_q == '0) ? TAG_W'(NUM_TAGS - 1) : alloc_q - 1'b1;
  assign flush_tgt = req_acc ? alloc_q : last_ptr;

  for (genvar i = 0; i < NUM_TAGS; i++) begin : g_slot
    localparam logic [TAG_W-1:0] IDX = TAG_W'(i);

    assign req_sel[i]   = req_acc && (alloc_q == IDX);
    assign reuse_sel[i] = bus.tag_reuse && !req_acc && (last_ptr == IDX) &&
                          (slot_state[i] != TAG_FREE);
    assign flush_sel[i] = bus.tag_flush && (flush_tgt == IDX) &&
                          (req_acc || slot_state[i] != TAG_FREE);
    assign ld_sel[i]    = ld_acc && (ld_q == IDX);
    assign cmp_sel[i]   = cmp_acc && (cmp_q == IDX);
    assign st_sel[i]    = st_acc && (st_q == IDX);

    tag_pool_manager_slot #(
      .REUSE_CNT_W  (REUSE_CNT_W),
      .STORE_ENABLED(STORE_ENABLED)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req_sel[i]),
      .reuse_i   (reuse_sel[i]),
      .flush_i   (flush_sel[i]),
      .ld_done_i (ld_sel[i]),
      .cmp_done_i(cmp_sel[i]),
      .st_done_i (st_sel[i]),
      .bias_sw_i (bus.tag_bias_prev_sw),
      .ddr_sw_i  (bus.tag_ddr_pe_sw),
      .state_o   (slot_state[i]),
      .bias_o    (slot_bias[i]),
      .ddr_o     (slot_ddr[i]),
      .retire_o  (slot_retire[i]),
      .sat_o     (slot_sat[i])
    );

    assign dbg_slot_state_o[i*TAG_STATE_W +: TAG_STATE_W] = slot_state[i];
  end

  always_comb begin
    alloc_d = req_acc ? ptr_inc(alloc_q) : alloc_q;
    ld_d    = ld_acc  ? ptr_inc(ld_q)    : ld_q;
    cmp_d   = retire  ? ptr_inc(cmp_q)   : cmp_q;
    st_d    = st_acc  ? ptr_inc(st_q)    : st_q;
    ovf_d   = ovf_q | (|slot_sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q <= '0;
      ld_q    <= '0;
      cmp_q   <= '0;
      st_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      ld_q    <= ld_d;
      cmp_q   <= cmp_d;
      st_q    <= st_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.tag_ready            = tag_ready;
  assign bus.tag_id               = alloc_q;
  assign bus.ldmem_tag_ready      = ld_ready;
  assign bus.ldmem_tag_id         = ld_q;
  assign bus.compute_tag_ready    = cmp_ready;
  assign bus.compute_tag_id       = cmp_q;
  assign bus.compute_bias_prev_sw = slot_bias[cmp_q];
  assign bus.next_compute_tag     = retire;
  assign bus.stmem_tag_ready      = st_ready;
  assign bus.stmem_tag_id         = st_q;
  assign bus.stmem_ddr_pe_sw      = slot_ddr[st_q];
  assign bus.reuse_overflow       = ovf_q;

endmodule
